param_seq_ctrl: RTL and testbench



---
 rtl/param_seq_pkg.sv | 30 +++
 rtl/seq_onehot_dec.sv | 20 ++
 rtl/param_seq_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_param_seq_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/param_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | param_seq_pkg : shared types and constants for param_seq_ctrl        |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package param_seq_pkg;

   typedef enum logic [1:0] {
      MODE_FREE     = 2'b00,
      MODE_ONESHOT  = 2'b01,
      MODE_PINGPONG = 2'b10,
      MODE_STEP     = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      PAUSED = 2'b10
   } ctrl_e;

   localparam logic UP   = 1'b0;
   localparam logic DOWN = 1'b1;

   // Timed modes advance on the dwell counter; step mode advances on ADV.
   function automatic logic is_timed(input mode_e m);
      return (m != MODE_STEP);
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_onehot_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_onehot_dec : binary position to one-hot decoder                  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module seq_onehot_dec #(
   parameter int NUM_STATES = 32
) (
   input  logic [$clog2(NUM_STATES)-1:0] i_bin,
   output logic [NUM_STATES-1:0]         o_onehot
);

   localparam int SW = $clog2(NUM_STATES);

   for (genvar i = 0; i < NUM_STATES; i++) begin : g_bit
      assign o_onehot[i] = (i_bin == SW'(i));
   end

endmodule
`default_nettype wire

// File: rtl/param_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | param_seq_ctrl : parametrised step sequencer (free/one-shot/ping-    |
// |                  pong/step) with dwell timer and wrap counter        |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module param_seq_ctrl
   import param_seq_pkg::*;
#(
   parameter int NUM_STATES = 32,
   parameter int DWELL_W    = 4,
   parameter int WRAP_W     = 8,
   localparam int SW        = $clog2(NUM_STATES)
) (
   input  logic                  CK,
   input  logic                  RN,
   input  logic                  CLR,
   input  logic                  START,
   input  logic                  HOLD,
   input  logic [1:0]            MODE,
   input  logic                  ADV,
   input  logic [DWELL_W-1:0]    DWELL,
   output logic [SW-1:0]         STATE,
   output logic [NUM_STATES-1:0] DEC,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  WRAP,
   output logic [WRAP_W-1:0]     WRAP_CNT
);

   localparam logic [SW-1:0]         c_last    = SW'(NUM_STATES - 1);
   localparam logic [NUM_STATES-1:0] c_dec_rst = NUM_STATES'(1);

   ctrl_e               r_ctrl;
   logic [SW-1:0]       r_pos;
   logic                r_dir;
   logic [DWELL_W-1:0]  r_dwell;
   logic [WRAP_W-1:0]   r_wrap_cnt;
   logic [NUM_STATES-1:0] r_dec;
   logic                r_busy;
   logic                r_done;
   logic                r_wrap;

   ctrl_e               w_ctrl_nxt;
   logic [SW-1:0]       w_pos_nxt;
   logic                w_dir_nxt;
   logic [DWELL_W-1:0]  w_dwell_nxt;
   logic [WRAP_W-1:0]   w_wrap_cnt_nxt;
   logic [NUM_STATES-1:0] w_dec_nxt;
   logic                w_busy_nxt;
   logic                w_done_nxt;
   logic                w_wrap_nxt;
   logic                w_done_ev;
   logic                w_wrap_ev;
   logic                w_adv;
   logic                w_go_up;
   mode_e               w_mode;

   assign w_mode = mode_e'(MODE);

   seq_onehot_dec #(
      .NUM_STATES (NUM_STATES)
   ) u_dec (
      .i_bin    (w_pos_nxt),
      .o_onehot (w_dec_nxt)
   );

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         r_ctrl     <= IDLE;
         r_pos      <= '0;
         r_dir      <= UP;
         r_dwell    <= '0;
         r_wrap_cnt <= '0;
         r_dec      <= c_dec_rst;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_wrap     <= 1'b0;
      end else begin
         r_ctrl     <= w_ctrl_nxt;
         r_pos      <= w_pos_nxt;
         r_dir      <= w_dir_nxt;
         r_dwell    <= w_dwell_nxt;
         r_wrap_cnt <= w_wrap_cnt_nxt;
         r_dec      <= w_dec_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_wrap     <= w_wrap_nxt;
      end
   end

   always_comb begin
      w_ctrl_nxt     = r_ctrl;
      w_pos_nxt      = r_pos;
      w_dir_nxt      = r_dir;
      w_dwell_nxt    = r_dwell;
      w_wrap_cnt_nxt = r_wrap_cnt;
      w_done_ev      = 1'b0;
      w_wrap_ev      = 1'b0;
      w_adv          = 1'b0;
      w_go_up        = 1'b0;

      if (CLR) begin
         w_ctrl_nxt     = IDLE;
         w_pos_nxt      = '0;
         w_dir_nxt      = UP;
         w_dwell_nxt    = '0;
         w_wrap_cnt_nxt = '0;
      end else begin
         case (r_ctrl)
            IDLE: begin
               if (START) begin
                  w_ctrl_nxt  = RUN;
                  w_pos_nxt   = '0;
                  w_dir_nxt   = UP;
                  w_dwell_nxt = '0;
               end
            end
            RUN: begin
               if (HOLD) begin
                  w_ctrl_nxt = PAUSED;
               end else begin
                  w_adv = is_timed(w_mode) ? (r_dwell >= DWELL) : ADV;
                  if (w_adv) begin
                     w_dwell_nxt = '0;
                     case (w_mode)
                        MODE_ONESHOT: begin
                           if (r_pos >= c_last) begin
                              w_pos_nxt  = '0;
                              w_ctrl_nxt = IDLE;
                              w_done_ev  = 1'b1;
                           end else begin
                              w_pos_nxt = r_pos + SW'(1);
                           end
                        end
                        MODE_PINGPONG: begin
                           // Bounce off either end even if DIR was left pointing outward by a mode change.
                           w_go_up = ((r_dir == UP) && (r_pos != c_last)) || (r_pos == '0);
                           if (w_go_up) begin
                              w_pos_nxt = r_pos + SW'(1);
                              w_dir_nxt = (w_pos_nxt == c_last) ? DOWN : UP;
                           end else begin
                              w_pos_nxt = r_pos - SW'(1);
                              if (w_pos_nxt == '0) begin
                                 w_dir_nxt = UP;
                                 w_wrap_ev = 1'b1;
                              end else begin
                                 w_dir_nxt = DOWN;
                              end
                           end
                        end
                        default: begin
                           w_dir_nxt = UP;
                           if (r_pos >= c_last) begin
                              w_pos_nxt = '0;
                              w_wrap_ev = 1'b1;
                           end else begin
                              w_pos_nxt = r_pos + SW'(1);
                           end
                        end
                     endcase
                  end else if (is_timed(w_mode)) begin
                     w_dwell_nxt = r_dwell + DWELL_W'(1);
                  end else begin
                     w_dwell_nxt = '0;
                  end
                  if (w_wrap_ev && (r_wrap_cnt != '1)) begin
                     w_wrap_cnt_nxt = r_wrap_cnt + WRAP_W'(1);
                  end
               end
            end
            PAUSED: begin
               if (!HOLD) begin
                  w_ctrl_nxt = RUN;
               end
            end
            default: begin
               w_ctrl_nxt = IDLE;
               w_pos_nxt  = '0;
               w_dir_nxt  = UP;
            end
         endcase
      end
   end

   always_comb begin
      w_busy_nxt = (w_ctrl_nxt != IDLE);
      w_done_nxt = w_done_ev;
      w_wrap_nxt = w_wrap_ev;
   end

   assign STATE    = r_pos;
   assign DEC      = r_dec;
   assign BUSY     = r_busy;
   assign DONE     = r_done;
   assign WRAP     = r_wrap;
   assign WRAP_CNT = r_wrap_cnt;

endmodule
`default_nettype wire

// File: tb/tb_param_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_param_seq_ctrl : directed vectors for param_seq_ctrl (N=5, W=2)   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_param_seq_ctrl;

   localparam int N  = 5;
   localparam int DW = 4;
   localparam int WW = 2;
   localparam int SW = 3;

   logic          CK;
   logic          RN;
   logic          CLR;
   logic          START;
   logic          HOLD;
   logic [1:0]    MODE;
   logic          ADV;
   logic [DW-1:0] DWELL;
   logic [SW-1:0] STATE;
   logic [N-1:0]  DEC;
   logic          BUSY;
   logic          DONE;
   logic          WRAP;
   logic [WW-1:0] WRAP_CNT;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       clr;
      logic       start;
      logic       hold;
      logic [1:0] mode;
      logic       adv;
      logic [3:0] dwell;
      int         st;
      logic       busy;
      logic       done;
      logic       wrap;
      int         wcnt;
   } vec_t;

   vec_t tbl[$];

   param_seq_ctrl #(
      .NUM_STATES (N),
      .DWELL_W    (DW),
      .WRAP_W     (WW)
   ) dut (
      .CK       (CK),
      .RN       (RN),
      .CLR      (CLR),
      .START    (START),
      .HOLD     (HOLD),
      .MODE     (MODE),
      .ADV      (ADV),
      .DWELL    (DWELL),
      .STATE    (STATE),
      .DEC      (DEC),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .WRAP     (WRAP),
      .WRAP_CNT (WRAP_CNT)
   );

   initial begin
      CK = 1'b0;
      forever #5 CK = ~CK;
   end

   function automatic vec_t mk(input logic clr, input logic start, input logic [1:0] mode,
                               input logic [3:0] dwell, input int st, input logic busy,
                               input logic done, input logic wrap, input int wcnt);
      vec_t v;
      v.clr = clr; v.start = start; v.hold = 1'b0; v.mode = mode; v.adv = 1'b0;
      v.dwell = dwell; v.st = st; v.busy = busy; v.done = done; v.wrap = wrap; v.wcnt = wcnt;
      return v;
   endfunction

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int st, input logic busy, input logic done,
                          input logic wrap, input int wcnt);
      chk({tag, ".state"}, 32'(STATE), st);
      chk({tag, ".dec"}, 32'(DEC), 32'(1) << st);
      chk({tag, ".busy"}, 32'(BUSY), 32'(busy));
      chk({tag, ".done"}, 32'(DONE), 32'(done));
      chk({tag, ".wrap"}, 32'(WRAP), 32'(wrap));
      chk({tag, ".wcnt"}, 32'(WRAP_CNT), wcnt);
   endtask

   task automatic do_clr();
      CLR = 1'b1; START = 1'b0; HOLD = 1'b0; ADV = 1'b0;
      tick();
      CLR = 1'b0;
      chk_out("clr", 0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   initial begin
      int pp [8];
      int stp [7];
      int k;
      pp  = '{1, 2, 3, 4, 3, 2, 1, 0};
      stp = '{1, 2, 3, 4, 0, 1, 2};

      // One-shot, DWELL=0.
      tbl.push_back(mk(0, 1, 2'b01, 0, 0, 1, 0, 0, 0));
      for (int a = 1; a <= 4; a++) tbl.push_back(mk(0, 0, 2'b01, 0, a, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b01, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 2'b01, 0, 0, 0, 0, 0, 0));
      // Ping-pong, DWELL=0, 16 advances.
      tbl.push_back(mk(0, 1, 2'b10, 0, 0, 1, 0, 0, 0));
      for (int a = 1; a <= 16; a++)
         tbl.push_back(mk(0, 0, 2'b10, 0, pp[(a-1)%8], 1, 0, (a % 8) == 0, a / 8));
      // CLR beats START, then IDLE stays put.
      tbl.push_back(mk(1, 1, 2'b10, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b10, 0, 0, 0, 0, 0, 0));

      RN = 1'b1; CLR = 1'b0; START = 1'b0; HOLD = 1'b0; MODE = 2'b00; ADV = 1'b0; DWELL = '0;
      #2 RN = 1'b0;
      #1 chk_out("reset", 0, 1'b0, 1'b0, 1'b0, 0);
      tick();
      #1 RN = 1'b1;
      chk_out("reset_held", 0, 1'b0, 1'b0, 1'b0, 0);

      foreach (tbl[i]) begin
         CLR = tbl[i].clr; START = tbl[i].start; HOLD = tbl[i].hold;
         MODE = tbl[i].mode; ADV = tbl[i].adv; DWELL = tbl[i].dwell;
         tick();
         chk_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].busy, tbl[i].done, tbl[i].wrap, tbl[i].wcnt);
      end
      CLR = 1'b0; START = 1'b0;

      // Free-run, DWELL=2: three cycles per position, wrap 15 cycles after RUN entry.
      MODE = 2'b00; DWELL = 4'd2; START = 1'b1;
      tick();
      START = 1'b0;
      chk_out("free_k0", 0, 1'b1, 1'b0, 1'b0, 0);
      for (k = 1; k <= 15; k++) begin
         tick();
         chk_out($sformatf("free_k%0d", k), (k / 3) % 5, 1'b1, 1'b0, k == 15, (k >= 15) ? 1 : 0);
      end
      do_clr();

      // HOLD for 4 cycles at STATE=2, DWELL=3; the step finishes its remaining dwell afterwards.
      MODE = 2'b00; DWELL = 4'd3; START = 1'b1;
      tick();
      START = 1'b0;
      for (k = 1; k <= 10; k++) begin
         tick();
         chk_out($sformatf("hold_k%0d", k), k / 4, 1'b1, 1'b0, 1'b0, 0);
      end
      HOLD = 1'b1;
      for (k = 11; k <= 14; k++) begin
         tick();
         chk_out($sformatf("hold_frz%0d", k), 2, 1'b1, 1'b0, 1'b0, 0);
      end
      HOLD = 1'b0;
      tick();
      chk_out("hold_rel15", 2, 1'b1, 1'b0, 1'b0, 0);
      tick();
      chk_out("hold_rel16", 2, 1'b1, 1'b0, 1'b0, 0);
      tick();
      chk_out("hold_rel17", 3, 1'b1, 1'b0, 1'b0, 0);
      do_clr();

      // Step mode: 7 ADV pulses separated by idle gaps; DWELL ignored.
      MODE = 2'b11; DWELL = 4'd7; START = 1'b1;
      tick();
      START = 1'b0;
      chk_out("step_entry", 0, 1'b1, 1'b0, 1'b0, 0);
      for (int p = 0; p < 7; p++) begin
         for (int g = 0; g <= p % 3; g++) begin
            tick();
            chk_out($sformatf("step_gap%0d_%0d", p, g), (p == 0) ? 0 : stp[p-1], 1'b1, 1'b0, 1'b0,
                    (p >= 5) ? 1 : 0);
         end
         ADV = 1'b1;
         tick();
         ADV = 1'b0;
         chk_out($sformatf("step_adv%0d", p), stp[p], 1'b1, 1'b0, p == 4, (p >= 4) ? 1 : 0);
      end
      do_clr();

      // Saturation: five wraps on a 2-bit counter, WRAP keeps pulsing.
      MODE = 2'b00; DWELL = 4'd0; START = 1'b1;
      tick();
      START = 1'b0;
      for (k = 1; k <= 26; k++) begin
         tick();
         chk_out($sformatf("sat_k%0d", k), k % 5, 1'b1, 1'b0, (k % 5) == 0, (k / 5 > 3) ? 3 : k / 5);
      end

      // Asynchronous reset mid-cycle, no clock edge in between.
      #2 RN = 1'b0;
      #1 chk_out("async_rst", 0, 1'b0, 1'b0, 1'b0, 0);
      #2 RN = 1'b1;
      tick();
      chk_out("after_rst", 0, 1'b0, 1'b0, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
